// File: rtl/data_ram_pkg.sv
// Shared types for the load/store data memory: access size and response payload.
package data_ram_pkg;

   typedef enum logic [1:0] {
      BYTE      = 2'd0,
      HALF_WORD = 2'd1,
      WORD      = 2'd2
   } load_size_e;

   typedef struct packed {
      logic        fault;
      logic [31:0] data;
   } rsp_t;

endpackage

// File: rtl/data_ram.sv
// Byte-lane data memory with valid/ready requests, in-order responses and programmable read latency.
// Define RAM_MISALIGN_TRAP_EN to fault misaligned half-word/word accesses instead of aligning them.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int unsigned MEM_SIZE     = 4096,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] address_i,
   input  logic        wr_enable_i,
   input  load_size_e  size_i,
   input  logic        sign_extend_i,
   input  logic [31:0] data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_fault_o
);

   localparam int unsigned ADDRWIDTH = $clog2(MEM_SIZE);
   localparam int unsigned DEPTH     = READ_LATENCY + 1;
   localparam int unsigned CNTW      = $clog2(READ_LATENCY + 2);
   localparam logic [33:0] LIMIT     = 34'(MEM_SIZE) << 2;

   logic [31:0] mem [MEM_SIZE] = '{default: '0};

   logic                 accept_c;
   logic                 pop_c;
   logic                 is_byte_c;
   logic                 is_half_c;
   logic                 range_fault_c;
   logic                 misalign_c;
   logic                 fault_c;
   logic                 we_c;
   logic [1:0]           lane_c;
   logic [ADDRWIDTH-1:0] widx_c;
   logic [3:0]           be_c;
   logic [31:0]          wdata_c;
   logic [31:0]          rword_c;
   logic [31:0]          shifted_c;
   logic [31:0]          load_c;
   rsp_t                 rsp_c;

   logic                 p1_vld_q, p1_vld_d;
   rsp_t                 p1_q, p1_d;
   logic                 push_c;
   rsp_t                 push_data_c;
   logic                 placed_c;
   rsp_t                 fifo_q [DEPTH];
   rsp_t                 fifo_d [DEPTH];
   logic [DEPTH-1:0]     vld_q, vld_d;
   logic [CNTW-1:0]      outstanding_q, outstanding_d;
   logic                 ready_q, ready_d;

   // Request decode: lane selection, faults, store enables and formatted load result
   always_comb begin
      accept_c      = req_valid_i && ready_q && !rst_i;
      pop_c         = vld_q[0] && rsp_ready_i;
      is_byte_c     = (size_i == BYTE);
      is_half_c     = (size_i == HALF_WORD);
      widx_c        = address_i[ADDRWIDTH+1:2];
      range_fault_c = ({2'b00, address_i} >= LIMIT);

      lane_c = 2'b00;
      if (is_byte_c) begin
         lane_c = address_i[1:0];
      end else if (is_half_c) begin
         lane_c = {address_i[1], 1'b0};
      end

`ifdef RAM_MISALIGN_TRAP_EN
      misalign_c = (is_half_c && address_i[0]) ||
                   (!is_byte_c && !is_half_c && (address_i[1:0] != 2'b00));
`else
      misalign_c = 1'b0;
`endif
      fault_c = range_fault_c || misalign_c;

      be_c    = 4'hF;
      wdata_c = data_i;
      if (is_byte_c) begin
         be_c    = 4'b0001 << lane_c;
         wdata_c = {4{data_i[7:0]}};
      end else if (is_half_c) begin
         be_c    = 4'b0011 << lane_c;
         wdata_c = {2{data_i[15:0]}};
      end
      we_c = accept_c && wr_enable_i && !fault_c;

      rword_c   = mem[widx_c];
      shifted_c = rword_c >> {lane_c, 3'b000};
      if (is_byte_c) begin
         load_c = {{24{sign_extend_i & shifted_c[7]}}, shifted_c[7:0]};
      end else if (is_half_c) begin
         load_c = {{16{sign_extend_i & shifted_c[15]}}, shifted_c[15:0]};
      end else begin
         load_c = rword_c;
      end

      rsp_c.fault = fault_c;
      rsp_c.data  = (wr_enable_i || fault_c) ? 32'h0 : load_c;
   end

   // Store commit at the accept edge; memory contents survive reset
   always_ff @(posedge clk_i) begin
      if (we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) begin
               mem[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
         end
      end
   end

   // Latency stage, shift-register response FIFO (head at index 0) and credit counter
   always_comb begin
      p1_vld_d = accept_c;
      p1_d     = rsp_c;
      if (READ_LATENCY >= 2) begin
         push_c      = p1_vld_q;
         push_data_c = p1_q;
      end else begin
         push_c      = accept_c;
         push_data_c = rsp_c;
      end

      fifo_d = fifo_q;
      vld_d  = vld_q;
      if (pop_c) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            fifo_d[i] = fifo_q[i+1];
            vld_d[i]  = vld_q[i+1];
         end
         fifo_d[DEPTH-1] = '0;
         vld_d[DEPTH-1]  = 1'b0;
      end

      placed_c = 1'b0;
      if (push_c) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!vld_d[i] && !placed_c) begin
               fifo_d[i] = push_data_c;
               vld_d[i]  = 1'b1;
               placed_c  = 1'b1;
            end
         end
      end

      outstanding_d = outstanding_q + CNTW'(accept_c) - CNTW'(pop_c);
      ready_d       = (outstanding_d < CNTW'(DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p1_vld_q      <= 1'b0;
         p1_q          <= '0;
         vld_q         <= '0;
         outstanding_q <= '0;
         ready_q       <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         p1_vld_q      <= p1_vld_d;
         p1_q          <= p1_d;
         vld_q         <= vld_d;
         outstanding_q <= outstanding_d;
         ready_q       <= ready_d;
         fifo_q        <= fifo_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = vld_q[0];
   assign rsp_data_o  = fifo_q[0].data;
   assign rsp_fault_o = fifo_q[0].fault;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: directed requests push expected responses, a monitor checks them in order.
module tb_data_ram;
   import data_ram_pkg::*;

   localparam int unsigned MEM_SIZE = 1024;
   localparam int unsigned RL       = 2;

   logic        clk;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] address_i;
   logic        wr_enable_i;
   load_size_e  size_i;
   logic        sign_extend_i;
   logic [31:0] data_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic        rsp_fault_o;

   typedef struct {
      logic [31:0] d;
      logic        f;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   data_ram #(.MEM_SIZE(MEM_SIZE), .READ_LATENCY(RL)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .address_i    (address_i),
      .wr_enable_i  (wr_enable_i),
      .size_i       (size_i),
      .sign_extend_i(sign_extend_i),
      .data_i       (data_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_data_o   (rsp_data_o),
      .rsp_fault_o  (rsp_fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endfunction

   // Monitor: every presented response is compared to the queue head; pops only on handshake
   always @(negedge clk) begin
      if (!rst_i && rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data %h fault %b, required no response", rsp_data_o, rsp_fault_o);
         end else begin
            chk("rsp_data", rsp_data_o, exp_q[0].d);
            chk("rsp_fault", {31'b0, rsp_fault_o}, {31'b0, exp_q[0].f});
            if (rsp_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic issue(input logic wr, input load_size_e sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed, input logic ef, output int waited);
      exp_t e;
      waited = 0;
      @(negedge clk);
      req_valid_i   = 1'b1;
      wr_enable_i   = wr;
      size_i        = sz;
      sign_extend_i = sx;
      address_i     = a;
      data_i        = d;
      while (!req_ready_o && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: addr %h not accepted after %0d cycles, required acceptance", a, waited);
         req_valid_i = 1'b0;
      end else begin
         e.d = ed;
         e.f = ef;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         req_valid_i = 1'b0;
      end
   endtask

   task automatic req(input logic wr, input load_size_e sz, input logic sx, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] ed, input logic ef);
      int w;
      issue(wr, sz, sx, a, d, ed, ef, w);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] bp_addr [3];
   logic [31:0] bp_exp  [3];

   initial begin
      int acc;
      int w;
      exp_t e;
      rst_i         = 1'b1;
      req_valid_i   = 1'b0;
      wr_enable_i   = 1'b0;
      size_i        = WORD;
      sign_extend_i = 1'b0;
      address_i     = '0;
      data_i        = '0;
      rsp_ready_i   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      chk("rst_rsp_data", rsp_data_o, 32'd0);
      chk("rst_rsp_fault", {31'b0, rsp_fault_o}, 32'd0);

      // Byte lanes
      req(1'b1, WORD, 1'b0, 32'h10, 32'h0000_0000, 32'h0, 1'b0);
      req(1'b1, BYTE, 1'b0, 32'h12, 32'h1234_56A5, 32'h0, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h00A5_0000, 1'b0);
      req(1'b0, BYTE, 1'b1, 32'h12, 32'h0, 32'hFFFF_FFA5, 1'b0);
      req(1'b0, BYTE, 1'b0, 32'h12, 32'h0, 32'h0000_00A5, 1'b0);

      // Half-word lanes
      req(1'b1, HALF_WORD, 1'b0, 32'h22, 32'hDEAD_8001, 32'h0, 1'b0);
      req(1'b0, HALF_WORD, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
      req(1'b0, HALF_WORD, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h20, 32'h0, 32'h8001_0000, 1'b0);

      // Range faults
      req(1'b1, WORD, 1'b0, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
      req(1'b0, WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
      req(1'b0, WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
      req(1'b0, WORD, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0);

      // Misalignment
      req(1'b1, WORD, 1'b0, 32'h4, 32'h1122_3344, 32'h0, 1'b0);
`ifdef RAM_MISALIGN_TRAP_EN
      req(1'b0, WORD, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
      req(1'b0, HALF_WORD, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1);
      req(1'b1, HALF_WORD, 1'b0, 32'h7, 32'hFFFF_FFFF, 32'h0, 1'b1);
`else
      req(1'b0, WORD, 1'b0, 32'h6, 32'h0, 32'h1122_3344, 1'b0);
      req(1'b0, HALF_WORD, 1'b0, 32'h5, 32'h0, 32'h0000_3344, 1'b0);
      req(1'b0, HALF_WORD, 1'b1, 32'h7, 32'h0, 32'h0000_1122, 1'b0);
`endif
      req(1'b1, BYTE, 1'b0, 32'h7, 32'h0000_0080, 32'h0, 1'b0);
      req(1'b0, BYTE, 1'b1, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h4, 32'h0, 32'h8022_3344, 1'b0);

      // Latency from an empty pipe
      wait_drain();
      req(1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h00A5_0000, 1'b0);
      @(negedge clk);
      chk("lat_early_valid", {31'b0, rsp_valid_o}, 32'd0);
      @(negedge clk);
      chk("lat_due_valid", {31'b0, rsp_valid_o}, 32'd1);

      // Throughput with the consumer always ready
      wait_drain();
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) issue(1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h00A5_0000, 1'b0, w);
         else            issue(1'b0, WORD, 1'b0, 32'h20, 32'h0, 32'h8001_0000, 1'b0, w);
         chk("thru_wait", 32'(w), 32'd0);
      end

      // Backpressure: stalled consumer limits acceptance to READ_LATENCY+1
      wait_drain();
      bp_addr[0] = 32'h10; bp_exp[0] = 32'h00A5_0000;
      bp_addr[1] = 32'h20; bp_exp[1] = 32'h8001_0000;
      bp_addr[2] = 32'h4;  bp_exp[2] = 32'h8022_3344;
      rsp_ready_i = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid_i   = 1'b1;
         wr_enable_i   = 1'b0;
         size_i        = WORD;
         sign_extend_i = 1'b0;
         address_i     = bp_addr[(acc < 3) ? acc : 2];
         if (req_ready_o) begin
            e.d = bp_exp[(acc < 3) ? acc : 2];
            e.f = 1'b0;
            exp_q.push_back(e);
            acc++;
         end
      end
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_accepted", 32'(acc), 32'd3);
      chk("bp_req_ready", {31'b0, req_ready_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rsp_ready_i = 1'b1;
      wait_drain();

      // Reset with two loads outstanding and a store presented during reset
      rsp_ready_i = 1'b0;
      req(1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h00A5_0000, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h20, 32'h0, 32'h8001_0000, 1'b0);
      rst_i         = 1'b1;
      req_valid_i   = 1'b1;
      wr_enable_i   = 1'b1;
      size_i        = WORD;
      address_i     = 32'h30;
      data_i        = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      exp_q.delete();
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
         @(negedge clk);
      end
      req(1'b0, WORD, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
      req(1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h00A5_0000, 1'b0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/data_ram.md
# data_ram

Parametrised 32-bit data memory for the core's load/store unit. It accepts one request per cycle through a valid/ready handshake and selects the correct byte or half-word lane from the low address bits. It sign- or zero-extends load data and returns one in-order response per request, including writes, with a programmable read latency and response backpressure. It replaces the single-cycle, lane-0-only data RAM. Load and store results are committed in request order.

## Interface
- MEM_SIZE, 4096, depth in 32-bit words; power of two.
- READ_LATENCY, 1, cycles from request acceptance to earliest response; legal values are 1 or 2.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- address_i  in  32  byte address.
- wr_enable_i  in  1  1 = store, 0 = load.
- size_i  in  load_size_e  BYTE / HALF_WORD / WORD, from the types package.
- sign_extend_i  in  1  load extension mode; ignored for WORD and stores.
- data_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_data_o  out  32  load result; 0 for stores and faults.
- rsp_fault_o  out  1  request was faulted.

## Operation
- A request is accepted on a rising edge where req_valid_i && req_ready_o. Request inputs are sampled only at that edge.
- Word index: address_i[ADDRWIDTH+1:2], where ADDRWIDTH = $clog2(MEM_SIZE). Lane offset: address_i[1:0].
- **Range fault:** address_i >= 4*MEM_SIZE. The store is suppressed. The response has rsp_fault_o=1 and rsp_data_o=0.
- **Stores:**
  - BYTE writes data_i[7:0] to byte lane address_i[1:0].
  - HALF_WORD writes data_i[15:0] to bytes {address_i[1],0}..{address_i[1],1}.
  - WORD writes all four bytes.
  - Other bytes of the word are untouched. The memory update happens at the accept edge.
- **Loads:**
  - BYTE: lane byte, extended to 32 bits (sign-extended if sign_extend_i=1, zero-extended otherwise).
  - HALF_WORD: lane half-word, extended the same way.
  - WORD: full word.
  - Memory is read at the accept edge, so a load accepted the cycle after a store to the same word sees the new data.
- **Response FIFO:** depth READ_LATENCY+1. Every accepted request produces exactly one response, in acceptance order. A response pops at an edge where rsp_valid_o && rsp_ready_i.
- **Credit counter:** `outstanding`, width $clog2(READ_LATENCY+2), counts accepted-not-popped requests.
  - req_ready_o = (outstanding < READ_LATENCY+1), driven from registered state only. There is no combinational path from rsp_ready_i.
  - Simultaneous accept and pop leaves `outstanding` unchanged.
- While rsp_valid_o=1 and rsp_ready_i=0, rsp_data_o and rsp_fault_o stay stable.
- Memory is zero-initialised at time 0 and is not cleared by reset.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_fault_o=0, outstanding=0, FIFO empty, latency pipeline invalid.
- Reset mid-operation:
  - All in-flight and queued responses are discarded.
  - Stores accepted before reset remain committed.
  - A request presented in the reset cycle is not accepted.
- Latency: a request accepted at edge k has its response visible after edge k+READ_LATENCY-1, i.e. in cycle k+READ_LATENCY, when no older responses are queued.
- Throughput: with rsp_ready_i held at 1, one request per cycle is sustained indefinitely.
- Full: when outstanding = READ_LATENCY+1, req_ready_o=0. It returns to 1 in the cycle after the next pop.

## Configuration
- RAM_MISALIGN_TRAP_EN defined:
  - HALF_WORD with address_i[0]=1, or WORD with address_i[1:0]!=0, is a misalignment fault.
  - The store is suppressed, and the response carries rsp_fault_o=1 and rsp_data_o=0.
- RAM_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are forced to zero (natural alignment) and the access proceeds.
  - rsp_fault_o reports range faults only.

## Test plan
- **Byte-lane store/load:** store WORD 0x0000_0000 @0x10, then BYTE 0xA5 @0x12, then load WORD @0x10 → 0x00A5_0000. Load BYTE signed @0x12 → 0xFFFF_FFA5. Load BYTE unsigned @0x12 → 0x0000_00A5.
- **Half-word lanes:** store HALF 0x8001 @0x22, then load HALF signed @0x22 → 0xFFFF_8001. Load HALF unsigned @0x20 → 0x0000_0000.
- **Backpressure:** READ_LATENCY=2, req_valid_i=1 every cycle, rsp_ready_i=0 → exactly 3 requests accepted, then req_ready_o=0. Release rsp_ready_i → 3 responses in order, and data stays stable while stalled.
- **Range fault:** store @4*MEM_SIZE → rsp_fault_o=1, and a subsequent load of word 0 is unchanged.
- **Misalignment:** WORD load @0x6. With RAM_MISALIGN_TRAP_EN → fault=1, data=0. Without it → returns word @0x4, fault=0.
- **Reset mid-stream:** 2 loads outstanding, then assert rst_i for 1 cycle → no responses emitted afterwards, req_ready_o=1, and a prior store is still readable.
